// File: rtl/image_ctrl_pkg.sv
// image_ctrl_pkg: shared state type and sizing helpers for the image cache controller.
package image_ctrl_pkg;
  typedef enum logic {LOAD, SEND} state_e;
  function automatic int sq(input int n);
    return n * n;
  endfunction
  function automatic int nbits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/img_cache.sv
// img_cache: single-write, single-read pixel store with asynchronous read; contents are not reset.
module img_cache #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/image_ctrl.sv
// image_ctrl: buffers one row-major frame into a cache, then streams it out with (row, col) tags,
// zero-filling pixels the frame never supplied.
module image_ctrl
  import image_ctrl_pkg::*;
#(
  parameter int K_DIM  = 3,
  parameter int I_DIM  = 8,
  parameter int M_BITS = 16,
  parameter int M_CNT  = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [M_BITS-1:0]           in_data,
  input  logic                        in_last,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [M_BITS-1:0]           out_data,
  output logic [1:0][nbits(I_DIM)-1:0] out_user,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready
);
  localparam int I_SIZE = sq(I_DIM);
  localparam int I_BITS = nbits(I_DIM);
  localparam int J_BITS = nbits(I_SIZE);
  localparam int W_BITS = nbits(I_SIZE + 1);

  if (K_DIM < 1 || M_CNT < 1 || I_DIM < 1) begin : g_bad_cfg
    $error("image_ctrl: K_DIM, M_CNT and I_DIM must be positive");
  end

  state_e              state_q, state_d;
  logic [W_BITS-1:0]   wcnt_q, wcnt_d;
  logic [J_BITS-1:0]   j_q, j_d, raddr;
  logic [I_BITS-1:0]   row_q, row_d, col_q, col_d;
  logic [M_BITS-1:0]   data_q, data_d, rd_data;
  logic                valid_q, valid_d, last_q, last_d, we;

  // The read port always looks at the index that will be presented next.
  assign raddr = (state_q == SEND && !last_q) ? j_q + J_BITS'(1) : '0;

  img_cache #(.DEPTH(I_SIZE), .WIDTH(M_BITS), .AW(J_BITS)) u_cache (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (J_BITS'(wcnt_q)),
    .wdata_i (in_data),
    .raddr_i (raddr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LOAD;
      wcnt_q  <= '0;
      j_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      j_q     <= j_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    j_d     = j_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    we      = 1'b0;
    if (state_q == LOAD) begin
      if (in_valid) begin
        we     = wcnt_q < W_BITS'(I_SIZE);
        wcnt_d = we ? wcnt_q + W_BITS'(1) : wcnt_q;
        if (in_last) begin
          // Pixel 0 may be written on this very edge, so bypass the cache for a 1-pixel frame.
          state_d = SEND;
          valid_d = 1'b1;
          last_d  = (I_SIZE == 1);
          data_d  = (wcnt_q == '0) ? in_data : rd_data;
        end
      end
    end else if (out_ready) begin
      if (last_q) begin
        state_d = LOAD;
        wcnt_d  = '0;
        j_d     = '0;
        row_d   = '0;
        col_d   = '0;
        data_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        j_d    = raddr;
        col_d  = (col_q == I_BITS'(I_DIM - 1)) ? '0 : col_q + I_BITS'(1);
        row_d  = (col_q == I_BITS'(I_DIM - 1)) ? row_q + I_BITS'(1) : row_q;
        last_d = raddr == J_BITS'(I_SIZE - 1);
        data_d = (W_BITS'(raddr) < wcnt_q) ? rd_data : '0;
      end
    end
  end

  assign in_ready    = state_q == LOAD;
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign out_data    = data_q;
  assign out_user[1] = row_q;
  assign out_user[0] = col_q;
endmodule

// File: tb/tb_image_ctrl.sv
// tb_image_ctrl: randomized frames against a queue-based frame model of the image controller.
module tb_image_ctrl;
  localparam int I_DIM  = 8;
  localparam int M_BITS = 16;
  localparam int I_SIZE = I_DIM * I_DIM;
  localparam int I_BITS = 3;

  logic                        clk = 1'b0;
  logic                        rstn = 1'b0;
  logic [M_BITS-1:0]           in_data = '0;
  logic                        in_last = 1'b0;
  logic                        in_valid = 1'b0;
  logic                        in_ready;
  logic [M_BITS-1:0]           out_data;
  logic [1:0][I_BITS-1:0]      out_user;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  logic [M_BITS-1:0] frame_q [$];

  image_ctrl #(.K_DIM(3), .I_DIM(I_DIM), .M_BITS(M_BITS), .M_CNT(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_user  (out_user),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_user"}, out_user, 0);
  endtask

  // base < 0 selects random pixel data; otherwise pixel k = base + k.
  task automatic load_frame(input int n, input int base, input bit gaps);
    logic [M_BITS-1:0] d;
    frame_q.delete();
    for (int k = 0; k < n; k++) begin
      d = (base < 0) ? M_BITS'($urandom) : M_BITS'(base + k);
      while (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        out_ready = 1'($urandom);
        tick();
      end
      check("load_in_ready", in_ready, 1);
      check("load_out_valid", out_valid, 0);
      in_valid = 1'b1;
      in_data = d;
      in_last = (k == n - 1);
      out_ready = 1'($urandom);
      frame_q.push_back(d);
      tick();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = M_BITS'($urandom);
  endtask

  // mode 0: always ready, 1: toggling ready, 2: random ready. poke drives junk inputs during SEND.
  task automatic drain(input int mode, input bit poke);
    int j = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [M_BITS-1:0] pd, exp_d;
    logic [2*I_BITS-1:0] pu, exp_u;
    logic pl;
    while (j < I_SIZE && cyc < 2000) begin
      check("send_out_valid", out_valid, 1);
      check("send_in_ready", in_ready, 0);
      if (stalled) begin
        check("hold_data", out_data, pd);
        check("hold_user", out_user, pu);
        check("hold_last", out_last, pl);
      end
      pd = out_data;
      pu = out_user;
      pl = out_last;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom);
      if (poke) begin
        in_valid = 1'($urandom);
        in_data = M_BITS'($urandom);
        in_last = 1'($urandom);
      end
      if (out_ready) begin
        exp_d = (j < frame_q.size()) ? frame_q[j] : '0;
        exp_u = {I_BITS'(j / I_DIM), I_BITS'(j % I_DIM)};
        check("out_data", out_data, exp_d);
        check("out_user", out_user, exp_u);
        check("out_last", out_last, j == I_SIZE - 1);
        j++;
      end
      stalled = !out_ready;
      tick();
      cyc++;
    end
    if (j < I_SIZE) check("drain_timeout", j, I_SIZE);
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    check("after_in_ready", in_ready, 1);
    check("after_out_valid", out_valid, 0);
    if (mode == 0) check("ready_low_cycles", cyc, I_SIZE);
  endtask

  initial begin
    tick();
    tick();
    check_idle("reset");
    rstn = 1'b1;
    tick();
    check_idle("post_reset");

    load_frame(68, 0, 1'b0);
    drain(0, 1'b0);
    load_frame(68, 0, 1'b0);
    drain(1, 1'b0);
    load_frame(10, 100, 1'b0);
    drain(0, 1'b0);

    for (int k = 0; k < 30; k++) begin
      in_valid = 1'b1;
      in_data = M_BITS'(500 + k);
      tick();
    end
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check_idle("reset_in_load");
    tick();
    rstn = 1'b1;
    load_frame(64, 200, 1'b0);
    drain(0, 1'b0);

    load_frame(64, -1, 1'b0);
    drain(0, 1'b0);
    load_frame(64, -1, 1'b0);
    drain(0, 1'b0);

    load_frame(64, -1, 1'b0);
    drain(2, 1'b1);

    load_frame(64, 300, 1'b0);
    out_ready = 1'b1;
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    check_idle("reset_in_send");
    out_ready = 1'b0;
    tick();
    rstn = 1'b1;
    load_frame(3, 700, 1'b0);
    drain(0, 1'b0);

    load_frame(1, 900, 1'b0);
    drain(2, 1'b0);

    repeat (20) begin
      load_frame($urandom_range(1, 80), -1, 1'b1);
      drain(2, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
